counter_sequencer: RTL

Run controller for the synchronous up-counter datapath: start/stop/pause sequencing plus programmable terminal count. Contains its own WIDTH-bit synchronous counter, enabled only by the FSM. Supports one-shot and periodic (auto-reload) modes. Emits a terminal tick and a completion pulse. Sits between control logic and counter-driven consumers such as timers, dividers and sequenced strobes.

---
 rtl/counter_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/counter_sequencer.sv
// counter_sequencer: run controller with a built-in WIDTH-bit up-counter.
// It sequences start/stop/pause, holds a programmable terminal count, and
// supports one-shot and periodic (auto-reload) runs.
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous reset, active-low
//   start   1-cycle request: latch period/mode, clear count, begin run
//   stop    abort request, returns to IDLE
//   pause   level; freezes the count while in RUN/HOLD
//   mode    0 = one-shot, 1 = periodic; sampled with start
//   period  terminal count value; sampled with start
//   count   current counter value (registered)
//   state   IDLE=00, RUN=01, HOLD=10, DONE=11
//   busy    high in RUN or HOLD
//   tick    terminal-count strobe, one cycle per period
//   done    registered one-cycle pulse on entry to DONE
module counter_sequencer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StHold = 2'b10,
        StDone = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             at_term;

    assign at_term = (count_q == period_q);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        mode_d   = mode_q;
        case (state_q)
            StIdle, StDone: begin
                // stop > pause > start; a zero period request is ignored
                if (stop) begin
                    state_d = StIdle;
                    count_d = '0;
                end else if (!pause && start && (period != '0)) begin
                    period_d = period;
                    mode_d   = mode;
                    count_d  = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                    count_d = '0;
                end else if (pause) begin
                    // entering HOLD at terminal defers the tick until resume
                    state_d = StHold;
                end else if (at_term) begin
                    if (mode_q) begin
                        count_d = '0;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            StHold: begin
                if (stop) begin
                    state_d = StIdle;
                    count_d = '0;
                end else if (!pause) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
        done_d = (state_d == StDone) && (state_q != StDone);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            period_q <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
        end
    end

    assign count = count_q;
    assign state = state_q;
    assign busy  = (state_q == StRun) || (state_q == StHold);
    assign tick  = (state_q == StRun) && at_term && !pause && !stop;
    assign done  = done_q;

endmodule
